spi_tx: RTL

SPI master transmitter that drives SS_n, SCLK and MOSI to send one 8- or 16-bit word per request, MSB first. It is the stimulus side of the SPI trigger path. It generates frames whose sampling edge and length match what the SPI trigger receiver is configured for, so the protocol trigger can be exercised on-chip and in benches. All SPI outputs are registered.

---
 rtl/spi_tx.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_tx.sv
// -----------------------------------------------------------------------------
// spi_tx : SPI master transmitter (stimulus side of the SPI trigger path)
//
// Sends one 8- or 16-bit word per accepted start request, MSB first, framed
// by SS_n. The SCLK sampling edge and the frame length are chosen per frame so
// the on-chip SPI trigger receiver can be exercised with matching traffic.
// All SPI outputs come straight from flops.
//
// Frame shape (SCLK_DIV = D clk cycles per SCLK half period, N = 8 or 16):
//   SS_n low for D*(2N+2) clks = D setup + 2N SCLK phases + D hold.
//   SCLK idles high; 2N edges, first falling, last rising.
//
// Parameters:
//   SCLK_DIV  SCLK half period in clk cycles, legal 4..255 (default 8)
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   start    in   frame request, taken only when idle and not in the done cycle
//   tx_data  in   word to send (len8=1 sends tx_data[7:0])
//   len8     in   1 = 8-bit frame, 0 = 16-bit frame
//   edg      in   receiver sampling edge: 1 = rising, 0 = falling
//   MISO     in   slave data in (only used with SPI_TX_MISO_EN)
//   busy     out  high from the cycle after acceptance until done
//   done     out  one-clk pulse when the frame completes
//   rd_data  out  captured MISO word (0 when MISO capture is not built)
//   SS_n     out  active-low slave select
//   SCLK     out  serial clock, idles high
//   MOSI     out  serial data out
//
// Build option:
//   `define SPI_TX_MISO_EN  builds the MISO capture shift register and the
//                           rd_data register; otherwise rd_data is tied to 0.
// -----------------------------------------------------------------------------
module spi_tx #(
  parameter logic [7:0] SCLK_DIV = 8'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] tx_data,
  input  logic        len8,
  input  logic        edg,
  input  logic        MISO,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [4:0]  edge_q;
  logic [15:0] sr_q;
  logic        len8_q;
  logic        edg_q;
  logic        ss_n_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        busy_q;
  logic        done_q;

  logic        half_tick;
  logic        accept;
  logic [4:0]  last_edge;
  logic        adv_mosi;
  logic        samp_edge;

  // A start landing in the done cycle is dropped: the earliest new frame is
  // the clk after done.
  assign accept = (state_q == IDLE) && start && !done_q;

  // Half-period timer: wraps to 0 at SCLK_DIV-1, half_tick marks the wrap.
  always_comb begin
    half_tick = 1'b0;
    cnt_d     = 8'd0;
    if (cnt_q == (SCLK_DIV - 8'd1)) begin
      half_tick = 1'b1;
      cnt_d     = 8'd0;
    end else begin
      half_tick = 1'b0;
      cnt_d     = cnt_q + 8'd1;
    end
  end

  // Classify the SCLK edge produced on the next half_tick. edge_q holds the
  // number of edges already produced, so this edge is number edge_q+1, and it
  // is falling when SCLK is currently high.
  always_comb begin
    last_edge = len8_q ? 5'd15 : 5'd31;
    adv_mosi  = 1'b0;
    samp_edge = 1'b0;
    if (edg_q) begin
      // Receiver samples rising edges: advance on every falling edge except
      // the first (which precedes the first sample of the MSB).
      adv_mosi  = sclk_q && (edge_q != 5'd0);
      samp_edge = !sclk_q;
    end else begin
      // Receiver samples falling edges: advance on every rising edge except
      // the last (the LSB has already been sampled by then).
      adv_mosi  = !sclk_q && (edge_q != last_edge);
      samp_edge = sclk_q;
    end
  end

  // Frame sequencer with registered SPI outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 5'd0;
      sr_q    <= 16'h0000;
      len8_q  <= 1'b0;
      edg_q   <= 1'b0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= 8'd0;
          edge_q <= 5'd0;
          sclk_q <= 1'b1;
          mosi_q <= 1'b0;
          if (accept) begin
            state_q <= SETUP;
            len8_q  <= len8;
            edg_q   <= edg;
            // Left-justify 8-bit words so the MSB is always sr_q[15].
            sr_q    <= len8 ? {tx_data[7:0], 8'h00} : tx_data;
            mosi_q  <= len8 ? tx_data[7] : tx_data[15];
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          cnt_q <= cnt_d;
          if (half_tick) begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          cnt_q <= cnt_d;
          if (half_tick) begin
            sclk_q <= !sclk_q;
            if (adv_mosi) begin
              sr_q   <= {sr_q[14:0], 1'b0};
              mosi_q <= sr_q[14];
            end
            if (edge_q == last_edge) begin
              edge_q  <= 5'd0;
              state_q <= HOLD;
            end else begin
              edge_q <= edge_q + 5'd1;
            end
          end
        end
        HOLD: begin
          cnt_q <= cnt_d;
          if (half_tick) begin
            state_q <= IDLE;
            ss_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          edge_q  <= 5'd0;
          ss_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_TX_MISO_EN
  logic [15:0] miso_sr_q;
  logic [15:0] rd_data_q;

  // MISO capture on the receiver's sampling edge; published in the done cycle.
  // For 8-bit frames only 8 bits shift in, so the upper byte stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_sr_q <= 16'h0000;
      rd_data_q <= 16'h0000;
    end else begin
      if (accept) begin
        miso_sr_q <= 16'h0000;
      end else if ((state_q == SHIFT) && half_tick && samp_edge) begin
        miso_sr_q <= {miso_sr_q[14:0], MISO};
      end else begin
        miso_sr_q <= miso_sr_q;
      end
      if ((state_q == HOLD) && half_tick) begin
        rd_data_q <= miso_sr_q;
      end else begin
        rd_data_q <= rd_data_q;
      end
    end
  end

  assign rd_data = rd_data_q;
`else
  logic miso_unused;
  logic samp_unused;
  assign miso_unused = MISO;
  assign samp_unused = samp_edge;
  assign rd_data     = 16'h0000;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign SS_n = ss_n_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;

endmodule
